systolic_pe_array_2x2: RTL and testbench

//  2x2 output-stationary int8 MAC array, directly downstream of the tile sequencer FSM.
//  - Consumes the skewed operand streams a1X/a2X/bX1/bX2 and the push11/pushedge/push22 strobes.
//  - Accumulates one 2x2 output tile, captures the four sums as the push strobes arrive, and

---
 rtl/systolic_pe_array_2x2.sv | 111 +++++++++++
 tb/tb_systolic_pe_array_2x2.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_pe_array_2x2.sv
// 2x2 output-stationary signed MAC array with registered operand forwarding,
// per-PE tile capture and a valid/ready output register for the finished tile.
module systolic_pe_array_2x2 #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     acc_en,
  input  logic signed [DATA_W-1:0] a1X,
  input  logic signed [DATA_W-1:0] a2X,
  input  logic signed [DATA_W-1:0] bX1,
  input  logic signed [DATA_W-1:0] bX2,
  input  logic                     push11,
  input  logic                     pushedge,
  input  logic                     push22,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  c11,
  output logic signed [ACC_W-1:0]  c12,
  output logic signed [ACC_W-1:0]  c21,
  output logic signed [ACC_W-1:0]  c22,
  output logic [31:0]              tile_cnt,
  output logic                     ovf,
  output logic                     overrun
);

  // PE index order throughout: 0=PE11, 1=PE12, 2=PE21, 3=PE22
  logic signed [DATA_W-1:0]   fa11, fb11, fa21, fb12;
  logic signed [DATA_W-1:0]   op_a [4];
  logic signed [DATA_W-1:0]   op_b [4];
  logic signed [2*DATA_W-1:0] prod_w [4];
  logic signed [ACC_W-1:0]    prod_ext [4];
  logic signed [ACC_W-1:0]    sum [4];
  logic signed [ACC_W-1:0]    acc [4];
  logic signed [ACC_W-1:0]    stage [4];
  logic signed [ACC_W-1:0]    stage_next [4];
  logic [3:0]                 push;
  logic [3:0]                 add_ovf;
  logic                       load;

  assign op_a[0] = a1X;   assign op_b[0] = bX1;
  assign op_a[1] = fa11;  assign op_b[1] = bX2;
  assign op_a[2] = a2X;   assign op_b[2] = fb11;
  assign op_a[3] = fa21;  assign op_b[3] = fb12;

  assign push = {push22, pushedge, pushedge, push11};

  // The final tile element is taken straight from the capture path so the
  // tile reaches the output register on the same edge that samples push22.
  assign load = push22 & (~out_valid | out_ready);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      prod_w[i]     = op_a[i] * op_b[i];
      prod_ext[i]   = {{(ACC_W-2*DATA_W){prod_w[i][2*DATA_W-1]}}, prod_w[i]};
      sum[i]        = acc[i] + (acc_en ? prod_ext[i] : '0);
      add_ovf[i]    = acc_en & (acc[i][ACC_W-1] == prod_ext[i][ACC_W-1])
                             & (sum[i][ACC_W-1] != acc[i][ACC_W-1]);
      stage_next[i] = push[i] ? sum[i] : stage[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fa11 <= '0;
      fb11 <= '0;
      fa21 <= '0;
      fb12 <= '0;
      for (int i = 0; i < 4; i++) begin
        acc[i]   <= '0;
        stage[i] <= '0;
      end
      out_valid <= 1'b0;
      c11       <= '0;
      c12       <= '0;
      c21       <= '0;
      c22       <= '0;
      tile_cnt  <= '0;
      ovf       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      fa11 <= a1X;
      fb11 <= bX1;
      fa21 <= a2X;
      fb12 <= bX2;
      for (int i = 0; i < 4; i++) begin
        stage[i] <= stage_next[i];
        if (push[i])
          acc[i] <= '0;
        else if (acc_en)
          acc[i] <= sum[i];
      end
      if (|add_ovf)
        ovf <= 1'b1;
      if (load) begin
        out_valid <= 1'b1;
        c11       <= stage_next[0];
        c12       <= stage_next[1];
        c21       <= stage_next[2];
        c22       <= stage_next[3];
        tile_cnt  <= tile_cnt + 32'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (push22 & out_valid & ~out_ready)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_systolic_pe_array_2x2.sv
// Directed bench for systolic_pe_array_2x2; a narrow-accumulator second
// instance shares the inputs so signed wrap is reachable in a few cycles.
module tb_systolic_pe_array_2x2;

  logic               clk = 1'b0;
  logic               reset;
  logic               acc_en;
  logic signed [7:0]  a1X, a2X, bX1, bX2;
  logic               push11, pushedge, push22, out_ready;

  logic               out_valid;
  logic signed [31:0] c11, c12, c21, c22;
  logic [31:0]        tile_cnt;
  logic               ovf, overrun;

  logic               nv_out_valid;
  logic signed [17:0] nv_c11, nv_c12, nv_c21, nv_c22;
  logic [31:0]        nv_tile_cnt;
  logic               nv_ovf, nv_overrun;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  systolic_pe_array_2x2 dut (
    .clk(clk), .reset(reset), .acc_en(acc_en),
    .a1X(a1X), .a2X(a2X), .bX1(bX1), .bX2(bX2),
    .push11(push11), .pushedge(pushedge), .push22(push22),
    .out_ready(out_ready), .out_valid(out_valid),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .tile_cnt(tile_cnt), .ovf(ovf), .overrun(overrun)
  );

  systolic_pe_array_2x2 #(.DATA_W(8), .ACC_W(18)) dut_narrow (
    .clk(clk), .reset(reset), .acc_en(acc_en),
    .a1X(a1X), .a2X(a2X), .bX1(bX1), .bX2(bX2),
    .push11(push11), .pushedge(pushedge), .push22(push22),
    .out_ready(out_ready), .out_valid(nv_out_valid),
    .c11(nv_c11), .c12(nv_c12), .c21(nv_c21), .c22(nv_c22),
    .tile_cnt(nv_tile_cnt), .ovf(nv_ovf), .overrun(nv_overrun)
  );

  // Drive one cycle of inputs, then land 1 ns after the sampling edge.
  task automatic applyStimulus(input int va1, input int va2, input int vb1, input int vb2,
                               input logic en, input logic p11, input logic pe, input logic p22);
    a1X = 8'(va1); a2X = 8'(va2); bX1 = 8'(vb1); bX2 = 8'(vb2);
    acc_en = en; push11 = p11; pushedge = pe; push22 = p22;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(observed), $signed(expected));
    end
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic acceptTile(input string tag);
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    checkOutput(tag, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    reset = 1'b0;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_c11", c11, 32'd0);
    checkOutput("rst_cnt", tile_cnt, 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    idle();

    $display("[TB] single PE accumulate");
    for (int k = 0; k < 3; k++) applyStimulus(2, 0, 3, 0, 1, 0, 0, 0);
    applyStimulus(2, 0, 3, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
    checkOutput("t2_not_early", 32'(out_valid), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("t2_valid", 32'(out_valid), 32'd1);
    checkOutput("t2_c11", c11, 32'd24);
    checkOutput("t2_c12", c12, 32'd0);
    checkOutput("t2_c21", c21, 32'd0);
    checkOutput("t2_c22", c22, 32'd0);
    checkOutput("t2_cnt", tile_cnt, 32'd1);

    $display("[TB] reset mid-tile with a held tile");
    applyStimulus(1, 0, 1, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 1, 0, 0, 0);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    checkOutput("t1_valid", 32'(out_valid), 32'd0);
    checkOutput("t1_c11", c11, 32'd0);
    checkOutput("t1_cnt", tile_cnt, 32'd0);
    applyStimulus(2, 0, 2, 0, 1, 1, 1, 1);
    checkOutput("t1_fresh_c11", c11, 32'd4);
    checkOutput("t1_fresh_cnt", tile_cnt, 32'd1);
    acceptTile("t1_accept");
    idle();

    $display("[TB] forwarding skew into PE12");
    for (int k = 0; k < 3; k++) applyStimulus(2, 0, 0, 5, 1, 0, 0, 0);
    for (int k = 0; k < 2; k++) applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("t3_valid", 32'(out_valid), 32'd1);
    checkOutput("t3_c11", c11, 32'd0);
    checkOutput("t3_c12", c12, 32'd20);
    checkOutput("t3_cnt", tile_cnt, 32'd2);
    acceptTile("t3_accept");
    idle();

    $display("[TB] full 2x2 matrix product");
    applyStimulus(1, 0, 5, 0, 1, 0, 0, 0);
    applyStimulus(2, 3, 7, 6, 1, 1, 0, 0);
    applyStimulus(0, 4, 0, 8, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("t4_c11", c11, 32'd19);
    checkOutput("t4_c12", c12, 32'd22);
    checkOutput("t4_c21", c21, 32'd43);
    checkOutput("t4_c22", c22, 32'd50);
    checkOutput("t4_cnt", tile_cnt, 32'd3);
    acceptTile("t4_accept");

    $display("[TB] negative operands and accumulator wrap");
    reset = 1'b1;
    idle();
    reset = 1'b0;
    for (int k = 0; k < 7; k++) applyStimulus(-128, 0, -128, 0, 1, 0, 0, 0);
    checkOutput("t5_nv_ovf_before", 32'(nv_ovf), 32'd0);
    applyStimulus(-128, 0, -128, 0, 1, 0, 0, 0);
    checkOutput("t5_nv_ovf_set", 32'(nv_ovf), 32'd1);
    applyStimulus(-128, 0, -128, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("t5_c11", c11, 32'd147456);
    checkOutput("t5_ovf", 32'(ovf), 32'd0);
    checkOutput("t5_nv_c11", {{14{nv_c11[17]}}, nv_c11}, -32'sd114688);
    checkOutput("t5_cnt", tile_cnt, 32'd1);
    acceptTile("t5_accept");
    checkOutput("t5_nv_ovf_sticky", 32'(nv_ovf), 32'd1);

    $display("[TB] backpressure and overrun");
    applyStimulus(3, 0, 4, 0, 1, 1, 1, 1);
    checkOutput("t6_a_valid", 32'(out_valid), 32'd1);
    checkOutput("t6_a_c11", c11, 32'd12);
    checkOutput("t6_a_cnt", tile_cnt, 32'd2);
    idle();
    checkOutput("t6_hold_valid", 32'(out_valid), 32'd1);
    applyStimulus(5, 0, 5, 0, 1, 1, 1, 1);
    checkOutput("t6_b_c11_kept", c11, 32'd12);
    checkOutput("t6_b_overrun", 32'(overrun), 32'd1);
    checkOutput("t6_b_cnt", tile_cnt, 32'd2);
    idle();
    out_ready = 1'b1;
    applyStimulus(6, 0, 1, 0, 1, 1, 1, 1);
    out_ready = 1'b0;
    checkOutput("t6_c_valid", 32'(out_valid), 32'd1);
    checkOutput("t6_c_c11", c11, 32'd6);
    checkOutput("t6_c_cnt", tile_cnt, 32'd3);
    idle();
    checkOutput("t6_overrun_sticky", 32'(overrun), 32'd1);
    acceptTile("t6_accept");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
